// File: rtl/wf_window_animator_pkg.sv
// ============================================================================
// Module : wf_window_animator_pkg
// Shared constants for the waveform window animator: default limits, axis
// indices and the animator state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wf_window_animator_pkg;

    localparam int DEF_SX = 138;
    localparam int DEF_EX = 838;
    localparam int DEF_SY = 62;
    localparam int DEF_EY = 482;

    localparam int AX_SX  = 0;
    localparam int AX_EX  = 1;
    localparam int AX_SY  = 2;
    localparam int AX_EY  = 3;
    localparam int NUM_AX = 4;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_MOVING = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/wf_window_animator_axis.sv
// ============================================================================
// Module : wf_window_animator_axis
// One coordinate step: moves cur toward tgt by at most STEP, never overshooting.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wf_window_animator_axis #(
    parameter int W    = 10,
    parameter int STEP = 2
) (
    input  logic [W-1:0] i_cur,
    input  logic [W-1:0] i_tgt,
    output logic [W-1:0] o_nxt,
    output logic         o_arrive
);

    localparam logic [W-1:0] C_STEP = W'(STEP);

    always_comb begin
        o_nxt = i_cur;
        if (i_tgt > i_cur) begin
            o_nxt = ((i_tgt - i_cur) <= C_STEP) ? i_tgt : (i_cur + C_STEP);
        end else if (i_cur > i_tgt) begin
            o_nxt = ((i_cur - i_tgt) <= C_STEP) ? i_tgt : (i_cur - C_STEP);
        end
    end

    assign o_arrive = (o_nxt == i_tgt);

endmodule

`default_nettype wire

// File: rtl/wf_window_animator.sv
// ============================================================================
// Module : wf_window_animator
// Animates the live display window toward requested limits, one bounded step
// per qualifying frame tick, with a single pending target slot.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wf_window_animator
    import wf_window_animator_pkg::*;
#(
    parameter int W               = 10,
    parameter int STEP            = 2,
    parameter int FRAMES_PER_STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_frame_tick,
    input  logic         i_tgt_valid,
    output logic         o_tgt_ready,
    input  logic [W-1:0] i_tgt_sx,
    input  logic [W-1:0] i_tgt_ex,
    input  logic [W-1:0] i_tgt_sy,
    input  logic [W-1:0] i_tgt_ey,
    output logic [W-1:0] o_start_x,
    output logic [W-1:0] o_end_x,
    output logic [W-1:0] o_start_y,
    output logic [W-1:0] o_end_y,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_cfg_err
);

    localparam int CW = $clog2(FRAMES_PER_STEP) + 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(FRAMES_PER_STEP - 1);
    localparam logic [NUM_AX-1:0][W-1:0] C_DEF =
        {W'(DEF_EY), W'(DEF_SY), W'(DEF_EX), W'(DEF_SX)};

    state_t                    r_state, w_state_d;
    logic [NUM_AX-1:0][W-1:0]  r_lim, r_act, r_pend;
    logic [NUM_AX-1:0][W-1:0]  w_lim_d, w_act_d, w_pend_d, w_req, w_nxt;
    logic [NUM_AX-1:0]         w_arrive;
    logic                      r_pend_full, w_pend_full_d;
    logic [CW-1:0]             r_cnt, w_cnt_d;
    logic                      r_done, w_done_d, r_err, w_err_d;
    logic                      w_accept, w_well, w_load, w_update;

    assign w_req[AX_SX] = i_tgt_sx;
    assign w_req[AX_EX] = i_tgt_ex;
    assign w_req[AX_SY] = i_tgt_sy;
    assign w_req[AX_EY] = i_tgt_ey;

    generate
        for (genvar g = 0; g < NUM_AX; g++) begin : g_axis
            wf_window_animator_axis #(.W(W), .STEP(STEP)) u_axis (
                .i_cur    (r_lim[g]),
                .i_tgt    (r_act[g]),
                .o_nxt    (w_nxt[g]),
                .o_arrive (w_arrive[g])
            );
        end
    endgenerate

    assign w_accept = i_tgt_valid && !r_pend_full;
    assign w_well   = (i_tgt_sx < i_tgt_ex) && (i_tgt_sy < i_tgt_ey);
    assign w_load   = w_accept && w_well;
    assign w_update = (r_state == S_MOVING) && i_frame_tick && (r_cnt == C_CNT_LAST);

    always_comb begin
        w_state_d     = r_state;
        w_lim_d       = r_lim;
        w_act_d       = r_act;
        w_pend_d      = r_pend;
        w_pend_full_d = r_pend_full;
        w_cnt_d       = r_cnt;
        w_done_d      = 1'b0;
        w_err_d       = w_accept && !w_well;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_act_d = w_req;
                    if (w_req == r_lim) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_state_d = S_MOVING;
                        w_cnt_d   = '0;
                    end
                end
            end
            default: begin
                if (i_frame_tick) begin
                    w_cnt_d = (r_cnt == C_CNT_LAST) ? '0 : (r_cnt + CW'(1));
                end
                if (w_load) begin
                    w_pend_d      = w_req;
                    w_pend_full_d = 1'b1;
                end
                if (w_update) begin
                    w_lim_d = w_nxt;
                    if (&w_arrive) begin
                        w_done_d = 1'b1;
                        // A request landing on the completing edge bypasses the slot.
                        if (r_pend_full) begin
                            w_act_d       = r_pend;
                            w_pend_full_d = 1'b0;
                        end else if (w_load) begin
                            w_act_d       = w_req;
                            w_pend_full_d = 1'b0;
                            if (w_req == w_nxt) begin
                                w_state_d = S_IDLE;
                            end
                        end else begin
                            w_state_d = S_IDLE;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lim       <= C_DEF;
            r_act       <= C_DEF;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_lim       <= w_lim_d;
            r_act       <= w_act_d;
            r_pend      <= w_pend_d;
            r_pend_full <= w_pend_full_d;
            r_cnt       <= w_cnt_d;
            r_done      <= w_done_d;
            r_err       <= w_err_d;
        end
    end

    assign o_start_x   = r_lim[AX_SX];
    assign o_end_x     = r_lim[AX_EX];
    assign o_start_y   = r_lim[AX_SY];
    assign o_end_y     = r_lim[AX_EY];
    assign o_tgt_ready = !r_pend_full;
    assign o_busy      = (r_state == S_MOVING);
    assign o_done      = r_done;
    assign o_cfg_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_wf_window_animator.sv
// ============================================================================
// Module : tb_wf_window_animator
// Bench for wf_window_animator: two instances (1 and 3 frames per step)
// against a behavioural window model, plus directed literal checks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wf_window_animator;

    localparam int W    = 10;
    localparam int STEP = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_tick = 1'b0;
    logic         vld [2];
    logic [W-1:0] tsx = '0, tex = '0, tsy = '0, tey = '0;
    logic [W-1:0] lim_o [2][4];
    logic         rdy_o [2];
    logic         busy_o [2];
    logic         done_o [2];
    logic         err_o [2];

    int n_tests = 0;
    int n_fail  = 0;

    int m_lim  [2][4];
    int m_act  [2][4];
    int m_pend [2][4];
    int m_pn   [2];
    int m_busy [2];
    int m_frm  [2];
    int m_done [2];
    int m_err  [2];

    always #5 clk = ~clk;

    wf_window_animator #(.W(W), .STEP(STEP), .FRAMES_PER_STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_frame_tick(frame_tick),
        .i_tgt_valid(vld[0]), .o_tgt_ready(rdy_o[0]),
        .i_tgt_sx(tsx), .i_tgt_ex(tex), .i_tgt_sy(tsy), .i_tgt_ey(tey),
        .o_start_x(lim_o[0][0]), .o_end_x(lim_o[0][1]),
        .o_start_y(lim_o[0][2]), .o_end_y(lim_o[0][3]),
        .o_busy(busy_o[0]), .o_done(done_o[0]), .o_cfg_err(err_o[0])
    );

    wf_window_animator #(.W(W), .STEP(STEP), .FRAMES_PER_STEP(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_frame_tick(frame_tick),
        .i_tgt_valid(vld[1]), .o_tgt_ready(rdy_o[1]),
        .i_tgt_sx(tsx), .i_tgt_ex(tex), .i_tgt_sy(tsy), .i_tgt_ey(tey),
        .o_start_x(lim_o[1][0]), .o_end_x(lim_o[1][1]),
        .o_start_y(lim_o[1][2]), .o_end_y(lim_o[1][3]),
        .o_busy(busy_o[1]), .o_done(done_o[1]), .o_cfg_err(err_o[1])
    );

    task automatic chk(input string nm, input int k, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int approach(input int cur, input int tgt);
        if (tgt - cur > STEP)  return cur + STEP;
        if (cur - tgt > STEP)  return cur - STEP;
        return tgt;
    endfunction

    task automatic mreset(input int k);
        int d[4];
        d = '{138, 838, 62, 482};
        for (int c = 0; c < 4; c++) begin
            m_lim[k][c] = d[c]; m_act[k][c] = d[c]; m_pend[k][c] = 0;
        end
        m_pn[k] = 0; m_busy[k] = 0; m_frm[k] = 0; m_done[k] = 0; m_err[k] = 0;
    endtask

    task automatic mstep(input int k, input int fps);
        int  req[4];
        bit  newreq, upd, same;
        req = '{int'(tsx), int'(tex), int'(tsy), int'(tey)};
        newreq = 0;
        m_done[k] = 0;
        m_err[k]  = 0;
        if (vld[k] && m_pn[k] == 0) begin
            if (req[0] < req[1] && req[2] < req[3]) newreq = 1;
            else m_err[k] = 1;
        end
        if (m_busy[k] == 0) begin
            if (newreq) begin
                same = 1;
                for (int c = 0; c < 4; c++) begin
                    m_act[k][c] = req[c];
                    if (req[c] != m_lim[k][c]) same = 0;
                end
                if (same) m_done[k] = 1;
                else begin m_busy[k] = 1; m_frm[k] = 0; end
            end
        end else begin
            upd = 0;
            if (frame_tick) begin
                m_frm[k]++;
                if (m_frm[k] == fps) begin m_frm[k] = 0; upd = 1; end
            end
            if (upd) begin
                same = 1;
                for (int c = 0; c < 4; c++) begin
                    m_lim[k][c] = approach(m_lim[k][c], m_act[k][c]);
                    if (m_lim[k][c] != m_act[k][c]) same = 0;
                end
                if (same) begin
                    m_done[k] = 1;
                    if (m_pn[k] != 0) begin
                        for (int c = 0; c < 4; c++) m_act[k][c] = m_pend[k][c];
                        m_pn[k] = 0;
                    end else if (newreq) begin
                        newreq = 0;
                        same = 1;
                        for (int c = 0; c < 4; c++) begin
                            m_act[k][c] = req[c];
                            if (req[c] != m_lim[k][c]) same = 0;
                        end
                        if (same) m_busy[k] = 0;
                    end else begin
                        m_busy[k] = 0;
                    end
                end
            end
            if (newreq) begin
                for (int c = 0; c < 4; c++) m_pend[k][c] = req[c];
                m_pn[k] = 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreset(0);
            mreset(1);
        end else begin
            mstep(0, 1);
            mstep(1, 3);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                chk("limits", k, {lim_o[k][3], lim_o[k][2], lim_o[k][1], lim_o[k][0]},
                    {m_lim[k][3][9:0], m_lim[k][2][9:0], m_lim[k][1][9:0], m_lim[k][0][9:0]});
                chk("ready", k, 40'(rdy_o[k]), 40'(m_pn[k] == 0));
                chk("busy", k, 40'(busy_o[k]), 40'(m_busy[k] != 0));
                chk("done", k, 40'(done_o[k]), 40'(m_done[k] != 0));
                chk("cfg_err", k, 40'(err_o[k]), 40'(m_err[k] != 0));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin ftick(); cyc(); cyc(); end
    endtask

    task automatic set_tgt(input int a, input int b, input int c, input int d);
        tsx = W'(a); tex = W'(b); tsy = W'(c); tey = W'(d);
    endtask

    task automatic send(input int k, input int a, input int b, input int c, input int d);
        bit acc;
        set_tgt(a, b, c, d);
        vld[k] = 1'b1;
        acc = 0;
        for (int i = 0; i < 300 && !acc; i++) begin
            acc = rdy_o[k];
            cyc();
        end
        vld[k] = 1'b0;
        if (!acc) chk("send_timeout", k, 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vld[0] = 1'b0; vld[1] = 1'b0; frame_tick = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic chk_defaults(input int k);
        chk("rst_limits", k, {lim_o[k][3], lim_o[k][2], lim_o[k][1], lim_o[k][0]},
            {10'd482, 10'd62, 10'd838, 10'd138});
        chk("rst_busy", k, 40'(busy_o[k]), 0);
        chk("rst_ready", k, 40'(rdy_o[k]), 1);
    endtask

    initial begin
        vld[0] = 1'b0; vld[1] = 1'b0;
        do_reset();

        // async reset takes effect mid-clock
        send(0, 88, 888, 32, 512);
        tick(3);
        @(posedge clk); #2 rst_n = 1'b0; #1;
        chk_defaults(0);
        chk_defaults(1);
        cyc(); rst_n = 1'b1; cyc();

        // full sweep to max limits
        send(0, 88, 888, 32, 512);
        chk("t2_busy", 0, 40'(busy_o[0]), 1);
        tick(15);
        chk("t2_y_done", 0, {lim_o[0][3], lim_o[0][2], lim_o[0][0]}, {10'd512, 10'd32, 10'd108});
        tick(9);
        chk("t2_x24", 0, 40'(lim_o[0][0]), 90);
        chk("t2_busy24", 0, 40'(busy_o[0]), 1);
        ftick();
        chk("t2_done", 0, 40'(done_o[0]), 1);
        chk("t2_final", 0, {lim_o[0][1], lim_o[0][0]}, {10'd888, 10'd88});
        cyc();
        chk("t2_idle", 0, 40'(busy_o[0]), 0);

        // odd distance, no overshoot
        do_reset();
        send(0, 127, 838, 62, 482);
        ftick();
        chk("t3_first", 0, 40'(lim_o[0][0]), 136);
        cyc(); cyc();
        tick(4);
        chk("t3_fifth", 0, 40'(lim_o[0][0]), 128);
        ftick();
        chk("t3_last", 0, 40'(lim_o[0][0]), 127);
        chk("t3_done", 0, 40'(done_o[0]), 1);
        cyc(); cyc();

        // pending slot behaviour
        do_reset();
        send(0, 88, 888, 32, 512);
        tick(5);
        send(0, 138, 838, 62, 482);
        chk("t4_ready_low", 0, 40'(rdy_o[0]), 0);
        set_tgt(100, 800, 50, 500);
        vld[0] = 1'b1;
        tick(19);
        chk("t4_held", 0, 40'(rdy_o[0]), 0);
        ftick();
        chk("t4_done", 0, 40'(done_o[0]), 1);
        chk("t4_no_gap", 0, 40'(busy_o[0]), 1);
        chk("t4_ready_up", 0, 40'(rdy_o[0]), 1);
        cyc();
        vld[0] = 1'b0;
        chk("t4_third_queued", 0, 40'(rdy_o[0]), 0);
        for (int i = 0; i < 100 && busy_o[0]; i++) tick(1);
        chk("t4_drained", 0, 40'(busy_o[0]), 0);
        chk("t4_end", 0, {lim_o[0][3], lim_o[0][2], lim_o[0][1], lim_o[0][0]},
            {10'd500, 10'd50, 10'd800, 10'd100});

        // malformed target
        send(0, 500, 400, 62, 482);
        chk("t5_err", 0, 40'(err_o[0]), 1);
        chk("t5_busy", 0, 40'(busy_o[0]), 0);
        chk("t5_sx", 0, 40'(lim_o[0][0]), 100);
        cyc();
        chk("t5_err_pulse", 0, 40'(err_o[0]), 0);

        // three frames per step
        do_reset();
        send(1, 88, 888, 32, 512);
        tick(2);
        chk("t6_hold", 1, 40'(lim_o[1][0]), 138);
        ftick();
        chk("t6_step", 1, 40'(lim_o[1][0]), 136);
        cyc(); cyc();
        tick(2);
        chk("t6_rdy", 1, 40'(rdy_o[1]), 1);
        set_tgt(200, 700, 100, 400);
        vld[1] = 1'b1;
        ftick();
        vld[1] = 1'b0;
        chk("t6_old_tgt", 1, 40'(lim_o[1][0]), 134);
        chk("t6_pending", 1, 40'(rdy_o[1]), 0);
        tick(4);
        #2 rst_n = 1'b0; #1;
        chk_defaults(1);
        cyc(); rst_n = 1'b1; cyc();

        // randomized traffic on each instance
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int i = 0; i < 1200; i++) begin
                bit acc;
                int r, a, b;
                acc = vld[k] && rdy_o[k];
                frame_tick = ($urandom % 3 == 0);
                cyc();
                if (acc) vld[k] = 1'b0;
                else if (!vld[k] && ($urandom % 5 == 0)) begin
                    r = $urandom % 8;
                    if (r == 0) begin
                        a = $urandom_range(200, 300);
                        set_tgt(a, a - $urandom_range(0, 50), 60, 70);
                    end else if (r == 1) begin
                        set_tgt(m_lim[k][0], m_lim[k][1], m_lim[k][2], m_lim[k][3]);
                    end else begin
                        a = $urandom_range(100, 160);
                        b = $urandom_range(40, 80);
                        set_tgt(a, a + $urandom_range(1, 40), b, b + $urandom_range(1, 40));
                    end
                    vld[k] = 1'b1;
                end
                if (i == 600) begin
                    #2 rst_n = 1'b0; #1;
                    chk_defaults(k);
                    vld[k] = 1'b0;
                    frame_tick = 1'b0;
                    cyc(); rst_n = 1'b1;
                end
            end
            vld[k] = 1'b0;
            frame_tick = 1'b0;
        end
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
